axi_rd_rr_arbiter: RTL and testbench

//  Parametrised read-address/read-data arbiter for the AXI interconnect; shares one slave read port among NUM_MST masters.

---
 rtl/axi_rd_rr_arbiter_pkg.sv | 14 +
 rtl/axi_rd_rr_arbiter_rr_pick.sv | 32 +++
 rtl/axi_rd_rr_arbiter.sv | 116 +++++++++++
 tb/tb_axi_rd_rr_arbiter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/axi_rd_rr_arbiter_pkg.sv
// Shared types and helpers for the AXI read-channel round-robin arbiter.
package axi_rd_rr_arbiter_pkg;

  typedef enum logic {
    StIdle  = 1'b0,
    StGrant = 1'b1
  } arb_state_e;

  // Increment with wrap to zero at n.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/axi_rd_rr_arbiter_rr_pick.sv
// Combinational rotating-priority selector: first requester at or after i_ptr.
module axi_rd_rr_arbiter_rr_pick
  import axi_rd_rr_arbiter_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic [IW-1:0] w_cand;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    w_cand   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_cand = IW'((32'(i_ptr) + k) % N);
      if (!o_any && i_req[w_cand]) begin
        o_any            = 1'b1;
        o_idx            = w_cand;
        o_onehot[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_rd_rr_arbiter.sv
// Round-robin arbiter sharing one AXI slave read port among NUM_MST masters;
// a grant is held until every burst issued under it has returned RLAST.
module axi_rd_rr_arbiter
  import axi_rd_rr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MST     = 4,
  parameter int unsigned MAX_OUTST   = 2,
  parameter int unsigned BURST_QUOTA = 4,
  localparam int unsigned IW = $clog2(NUM_MST)
) (
  input  logic               ACLK,
  input  logic               ARESETn,
  input  logic [NUM_MST-1:0] m_arvalid,
  input  logic [NUM_MST-1:0] m_rready,
  input  logic               s_arready,
  input  logic               s_rvalid,
  input  logic               s_rlast,
  output logic [NUM_MST-1:0] grant,
  output logic [IW-1:0]      grant_idx,
  output logic               ar_enable,
  output logic               busy
);

  localparam int unsigned OW = $clog2(MAX_OUTST + 1);
  localparam int unsigned QW = $clog2(BURST_QUOTA + 1);

  arb_state_e         r_state, w_state_nxt;
  logic [NUM_MST-1:0] r_grant, w_grant_nxt;
  logic [IW-1:0]      r_grant_idx, w_grant_idx_nxt;
  logic [IW-1:0]      r_rr_ptr, w_rr_ptr_nxt;
  logic [OW-1:0]      r_outst, w_outst_nxt;
  logic [QW-1:0]      r_issued, w_issued_nxt;

  logic [NUM_MST-1:0] w_pick_onehot;
  logic [IW-1:0]      w_pick_idx;
  logic               w_pick_any;
  logic               w_granted;
  logic               w_ar_hs;
  logic               w_r_done;

  axi_rd_rr_arbiter_rr_pick #(
    .N (NUM_MST)
  ) u_pick (
    .i_req    (m_arvalid),
    .i_ptr    (r_rr_ptr),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx),
    .o_any    (w_pick_any)
  );

  assign w_granted = (r_state == StGrant);
  assign ar_enable = w_granted && (r_outst < OW'(MAX_OUTST)) && (r_issued < QW'(BURST_QUOTA));
  assign w_ar_hs   = m_arvalid[r_grant_idx] & s_arready & ar_enable;
  assign w_r_done  = w_granted & s_rvalid & m_rready[r_grant_idx] & s_rlast;

  assign grant     = r_grant;
  assign grant_idx = r_grant_idx;
  assign busy      = w_granted;

  always_comb begin
    w_state_nxt     = r_state;
    w_grant_nxt     = r_grant;
    w_grant_idx_nxt = r_grant_idx;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_outst_nxt     = r_outst;
    w_issued_nxt    = r_issued;

    unique case (r_state)
      StIdle: begin
        if (w_pick_any) begin
          w_state_nxt     = StGrant;
          w_grant_nxt     = w_pick_onehot;
          w_grant_idx_nxt = w_pick_idx;
        end
      end
      StGrant: begin
        // A stray RLAST with nothing outstanding is ignored rather than wrapping.
        if (w_ar_hs && !w_r_done) begin
          w_outst_nxt = r_outst + OW'(1);
        end else if (!w_ar_hs && w_r_done && (r_outst != '0)) begin
          w_outst_nxt = r_outst - OW'(1);
        end
        if (w_ar_hs) begin
          w_issued_nxt = r_issued + QW'(1);
        end
        if ((w_outst_nxt == '0) && !w_ar_hs &&
            (!m_arvalid[r_grant_idx] || (r_issued == QW'(BURST_QUOTA)))) begin
          w_state_nxt  = StIdle;
          w_grant_nxt  = '0;
          w_issued_nxt = '0;
          w_rr_ptr_nxt = IW'(wrap_inc(32'(r_grant_idx), NUM_MST));
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state     <= StIdle;
      r_grant     <= '0;
      r_grant_idx <= '0;
      r_rr_ptr    <= '0;
      r_outst     <= '0;
      r_issued    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_grant_idx <= w_grant_idx_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_outst     <= w_outst_nxt;
      r_issued    <= w_issued_nxt;
    end
  end

endmodule

// File: tb/tb_axi_rd_rr_arbiter.sv
// Self-checking bench: directed reset/outstanding scenarios, then randomized traffic
// checked cycle by cycle against a transaction-level arbitration model.
module tb_axi_rd_rr_arbiter;

  localparam int unsigned N     = 4;
  localparam int unsigned MAXO  = 2;
  localparam int unsigned QUOTA = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] m_arvalid;
  logic [N-1:0] m_rready;
  logic         s_arready;
  logic         s_rvalid;
  logic         s_rlast;
  logic [N-1:0] grant;
  logic [1:0]   grant_idx;
  logic         ar_enable;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: who holds the grant, where the rotation resumes, bursts in flight.
  int m_busy, m_g, m_ptr, m_outst, m_issued;

  axi_rd_rr_arbiter #(
    .NUM_MST     (N),
    .MAX_OUTST   (MAXO),
    .BURST_QUOTA (QUOTA)
  ) dut (
    .ACLK      (clk),
    .ARESETn   (rst_n),
    .m_arvalid (m_arvalid),
    .m_rready  (m_rready),
    .s_arready (s_arready),
    .s_rvalid  (s_rvalid),
    .s_rlast   (s_rlast),
    .grant     (grant),
    .grant_idx (grant_idx),
    .ar_enable (ar_enable),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_g = 0; m_ptr = 0; m_outst = 0; m_issued = 0;
  endtask

  function automatic int model_ar_en();
    return (m_busy != 0 && m_outst < MAXO && m_issued < QUOTA) ? 1 : 0;
  endfunction

  // One clock: check the combinational enable, advance the model, check registered outputs.
  task automatic tick();
    int hs, done;
    #1;
    check_eq("ar_enable", ar_enable, model_ar_en());
    if (m_busy == 0) begin
      for (int k = 0; k < N; k++) begin
        if (m_busy == 0 && m_arvalid[(m_ptr + k) % N]) begin
          m_g    = (m_ptr + k) % N;
          m_busy = 1;
        end
      end
    end else begin
      hs   = (m_arvalid[m_g] && s_arready && model_ar_en() != 0) ? 1 : 0;
      done = (s_rvalid && m_rready[m_g] && s_rlast) ? 1 : 0;
      m_outst  = m_outst + hs - done;
      if (m_outst < 0) m_outst = 0;
      m_issued = m_issued + hs;
      if (m_outst == 0 && hs == 0 && (!m_arvalid[m_g] || m_issued == QUOTA)) begin
        m_busy   = 0;
        m_issued = 0;
        m_ptr    = (m_g + 1) % N;
      end
    end
    @(posedge clk);
    #1;
    check_eq("busy", busy, m_busy);
    check_eq("grant", grant, (m_busy != 0) ? (1 << m_g) : 0);
    if (m_busy != 0) check_eq("grant_idx", grant_idx, m_g);
  endtask

  initial begin
    rst_n     = 1'b0;
    m_arvalid = 4'b1111;
    m_rready  = '0;
    s_arready = 1'b0;
    s_rvalid  = 1'b0;
    s_rlast   = 1'b0;
    model_reset();

    // Reset held with everyone requesting: nothing may be granted.
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_grant", grant, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ar_enable", ar_enable, 0);
    check_eq("rst_grant_idx", grant_idx, 0);
    #1 rst_n = 1'b1;
    tick();
    check_eq("first_grant", grant, 4'b0001);

    // m0 drops ARVALID without a handshake -> release, m1 next.
    m_arvalid = 4'b0010;
    tick();
    check_eq("m0_released", busy, 0);
    tick();
    check_eq("m1_grant", grant, 4'b0010);

    // Two ARs fill the outstanding window.
    s_arready = 1'b1;
    tick();
    tick();
    #1;
    check_eq("outst_full_block", ar_enable, 0);
    m_rready = 4'b0010;
    s_rvalid = 1'b1;
    s_rlast  = 1'b1;
    tick();
    check_eq("held_after_first_rlast", grant, 4'b0010);
    check_eq("window_reopened", ar_enable, 1);
    s_rvalid = 1'b0;
    tick();

    // Asynchronous reset mid-burst clears outputs without waiting for a clock.
    #1 rst_n = 1'b0;
    #1;
    check_eq("async_rst_grant", grant, 0);
    check_eq("async_rst_busy", busy, 0);
    check_eq("async_rst_ar_enable", ar_enable, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("in_rst_grant", grant, 0);
    #1 rst_n = 1'b1;
    m_arvalid = '0;
    s_arready = 1'b0;
    tick();
    check_eq("no_req_no_grant", busy, 0);
    m_arvalid = 4'b1000;
    tick();
    check_eq("m3_after_rst", grant, 4'b1000);

    // Randomized traffic; requests are sticky so quotas and long holds occur.
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(99) < 20) m_arvalid[b] = ($urandom_range(99) < 65);
      end
      m_rready  = N'($urandom_range(15) | $urandom_range(15));
      s_arready = ($urandom_range(99) < 70);
      s_rvalid  = (m_outst > 0) && ($urandom_range(99) < 55);
      s_rlast   = ($urandom_range(99) < 70);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
